lbus_sram_responder: RTL and testbench



---
 rtl/lbus_sram_responder.sv | 164 ++++++++++++++++
 tb/tb_lbus_sram_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbus_sram_responder.sv
// Emulated 512K x 8 asynchronous SRAM target. The strobes are registered once and decoded by an IDLE/WRITE/READ FSM.
// The data lives in a block-RAM array. Sticky error flags and saturating access counters support board bring-up.
module lbus_sram_responder #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] sram_addr,
  input  logic        sram_cen,
  input  logic        sram_oen,
  input  logic        sram_wen,
  input  logic [7:0]  sram_dq_in,
  output logic [7:0]  sram_dq_out,
  output logic        sram_dq_oe,
  input  logic        clr_stats,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        conflict_err,
  output logic        range_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  logic [18:0] addr_q;
  logic        cen_q, oen_q, wen_q;
  logic [7:0]  dq_in_q;

  state_t      state_q, state_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        conflict_q, conflict_d;
  logic        range_q, range_d;

  logic [7:0]  mem [DEPTH];

  logic        wr_req, rd_req, addr_oor, wr_oor;
  logic        commit, mem_we, rd_inc, wr_inc, range_set;
  logic [7:0]  mem_rd;

  assign wr_req   = !cen_q && !wen_q;
  assign rd_req   = !cen_q && !oen_q && wen_q;
  assign addr_oor = |addr_q[18:ADDR_W];
  assign wr_oor   = |wr_addr_q[18:ADDR_W];
  assign mem_we   = commit && !wr_oor;

  // Write-first bypass so a read never sees stale data for a byte being committed.
  assign mem_rd = (mem_we && (wr_addr_q[ADDR_W-1:0] == addr_q[ADDR_W-1:0]))
                  ? wr_data_q : mem[addr_q[ADDR_W-1:0]];

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    dq_out_d  = dq_out_q;
    dq_oe_d   = 1'b0;
    commit    = 1'b0;
    rd_inc    = 1'b0;
    wr_inc    = 1'b0;
    range_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d   = WRITE;
          wr_addr_d = addr_q;
          wr_data_d = dq_in_q;
          range_set = addr_oor;
        end else if (rd_req) begin
          state_d   = READ;
          rd_inc    = 1'b1;
          range_set = addr_oor;
        end
      end
      WRITE: begin
        if (wr_req) begin
          wr_data_d = dq_in_q;
        end else begin
          state_d = IDLE;
          commit  = 1'b1;
          wr_inc  = 1'b1;
        end
      end
      READ: begin
        if (wr_req) begin
          state_d   = WRITE;
          wr_addr_d = addr_q;
          wr_data_d = dq_in_q;
          range_set = addr_oor;
        end else if (rd_req) begin
          dq_oe_d  = 1'b1;
          dq_out_d = addr_oor ? 8'hFF : mem_rd;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_count_d = (rd_inc && rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
    wr_count_d = (wr_inc && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    conflict_d = conflict_q | (!cen_q && !oen_q && !wen_q);
    range_d    = range_q | range_set;
    if (clr_stats) begin
      rd_count_d = 16'd0;
      wr_count_d = 16'd0;
      conflict_d = 1'b0;
      range_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cen_q      <= 1'b1;
      oen_q      <= 1'b1;
      wen_q      <= 1'b1;
      dq_in_q    <= '0;
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      conflict_q <= 1'b0;
      range_q    <= 1'b0;
    end else begin
      addr_q     <= sram_addr;
      cen_q      <= sram_cen;
      oen_q      <= sram_oen;
      wen_q      <= sram_wen;
      dq_in_q    <= sram_dq_in;
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      conflict_q <= conflict_d;
      range_q    <= range_d;
    end
  end

  // A write pending when reset lands is dropped, so the array write is gated by reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[wr_addr_q[ADDR_W-1:0]] <= wr_data_q;
    end
  end

  assign sram_dq_out  = dq_out_q;
  assign sram_dq_oe   = dq_oe_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;
  assign conflict_err = conflict_q;
  assign range_err    = range_q;

endmodule

// File: tb/tb_lbus_sram_responder.sv
// Bench for lbus_sram_responder: directed scenarios with literal expectations plus randomized bus traffic,
// all checked every cycle against a history-based behavioural model.
module tb_lbus_sram_responder;

  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] sram_addr;
  logic        sram_cen, sram_oen, sram_wen;
  logic [7:0]  sram_dq_in;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe;
  logic        clr_stats;
  logic [15:0] rd_count, wr_count;
  logic        conflict_err, range_err;

  lbus_sram_responder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .sram_addr(sram_addr), .sram_cen(sram_cen),
    .sram_oen(sram_oen), .sram_wen(sram_wen), .sram_dq_in(sram_dq_in),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .clr_stats(clr_stats),
    .rd_count(rd_count), .wr_count(wr_count), .conflict_err(conflict_err),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: outputs are derived from the last three sampled bus cycles.
  typedef struct packed {
    logic [18:0] addr;
    logic        cen, oen, wen;
    logic [7:0]  dq;
  } smp_t;

  smp_t        h1, h2, h3;
  logic [18:0] m_wa;
  logic [7:0]  m_mem [1 << ADDR_W];
  bit          m_known [1 << ADDR_W];
  logic        m_oe;
  logic [7:0]  m_dq;
  bit          m_dq_known;
  logic [15:0] m_rd, m_wr;
  logic        m_cf, m_rg;

  function automatic bit is_w(smp_t s);
    return !s.cen && !s.wen;
  endfunction
  function automatic bit is_r(smp_t s);
    return !s.cen && !s.oen && s.wen;
  endfunction
  function automatic bit oor(logic [18:0] a);
    return |a[18:ADDR_W];
  endfunction
  function automatic smp_t idle_smp();
    return {19'd0, 1'b1, 1'b1, 1'b1, 8'd0};
  endfunction

  task automatic model_step();
    smp_t cur;
    cur = {sram_addr, sram_cen, sram_oen, sram_wen, sram_dq_in};
    if (!rst_n) begin
      m_oe = 1'b0; m_dq = 8'h00; m_dq_known = 1'b0;
      m_rd = 16'd0; m_wr = 16'd0; m_cf = 1'b0; m_rg = 1'b0;
      h1 = idle_smp(); h2 = idle_smp(); h3 = idle_smp();
    end else begin
      // A write burst ended one sample ago: commit its last byte.
      if (is_w(h2) && !is_w(h1)) begin
        if (!oor(m_wa)) begin
          m_mem[m_wa[ADDR_W-1:0]]   = h2.dq;
          m_known[m_wa[ADDR_W-1:0]] = 1'b1;
        end
        if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
      end
      m_oe = is_r(h1) && is_r(h2) && !is_w(h3);
      if (m_oe) begin
        if (oor(h1.addr)) begin
          m_dq = 8'hFF; m_dq_known = 1'b1;
        end else begin
          m_dq = m_mem[h1.addr[ADDR_W-1:0]];
          m_dq_known = m_known[h1.addr[ADDR_W-1:0]];
        end
      end
      if (is_r(h1) && !is_w(h2) && !(is_r(h2) && !is_w(h3))) begin
        if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
        if (oor(h1.addr)) m_rg = 1'b1;
      end
      if (is_w(h1) && !is_w(h2)) begin
        m_wa = h1.addr;
        if (oor(h1.addr)) m_rg = 1'b1;
      end
      if (!h1.cen && !h1.oen && !h1.wen) m_cf = 1'b1;
      if (clr_stats) begin
        m_rd = 16'd0; m_wr = 16'd0; m_cf = 1'b0; m_rg = 1'b0;
      end
      h3 = h2; h2 = h1; h1 = cur;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("dq_oe", 32'(sram_dq_oe), 32'(m_oe));
    if (m_oe && m_dq_known) chk("dq_out", 32'(sram_dq_out), 32'(m_dq));
    chk("rd_count", 32'(rd_count), 32'(m_rd));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("conflict_err", 32'(conflict_err), 32'(m_cf));
    chk("range_err", 32'(range_err), 32'(m_rg));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_idle();
    sram_cen = 1'b1; sram_oen = 1'b1; sram_wen = 1'b1;
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d, input int len);
    sram_addr = a; sram_dq_in = d; sram_cen = 1'b0; sram_wen = 1'b0;
    repeat (len) tick();
    set_idle();
    repeat (3) tick();
  endtask

  task automatic rd_lit(input string name, input logic [18:0] a, input logic [7:0] exp);
    sram_addr = a; sram_cen = 1'b0; sram_oen = 1'b0;
    tick(); tick();
    chk({name, "_oe_early"}, 32'(sram_dq_oe), 32'd0);
    tick();
    chk({name, "_oe"}, 32'(sram_dq_oe), 32'd1);
    chk({name, "_data"}, 32'(sram_dq_out), 32'(exp));
    set_idle();
    repeat (3) tick();
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1; tick(); clr_stats = 1'b0; tick();
  endtask

  initial begin
    int op, len;
    rst_n = 1'b0; clr_stats = 1'b0; sram_addr = '0; sram_dq_in = '0;
    set_idle();
    repeat (3) tick();
    chk("rst_dq_out", 32'(sram_dq_out), 32'h00);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_counts", 32'({rd_count, wr_count}), 32'd0);
    chk("rst_flags", 32'({conflict_err, range_err}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write then read.
    wr(19'h00123, 8'hA5, 4);
    rd_lit("wr_rd", 19'h00123, 8'hA5);
    chk("wr_rd_wr_count", 32'(wr_count), 32'd1);
    chk("wr_rd_rd_count", 32'(rd_count), 32'd1);

    // Data changing during a single write pulse.
    sram_addr = 19'h00040; sram_cen = 1'b0; sram_wen = 1'b0;
    sram_dq_in = 8'h11; tick();
    sram_dq_in = 8'h22; tick();
    sram_dq_in = 8'h33; tick();
    set_idle(); repeat (3) tick();
    rd_lit("last_byte", 19'h00040, 8'h33);

    // Streaming read over k*3 (1-cycle writes).
    for (int k = 0; k < 8; k++) wr(19'(k), 8'(k * 3), 1);
    pulse_clr();
    sram_addr = 19'd0; sram_cen = 1'b0; sram_oen = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      sram_addr = 19'(k);
      tick();
      if (k >= 1) chk("stream_data", 32'(sram_dq_out), 32'((k - 1) * 3));
    end
    tick();
    chk("stream_last", 32'(sram_dq_out), 32'd21);
    set_idle(); repeat (3) tick();
    chk("stream_rd_count", 32'(rd_count), 32'd1);

    // Out of range.
    pulse_clr();
    wr(19'h40000, 8'h5A, 2);
    chk("oor_range_err", 32'(range_err), 32'd1);
    chk("oor_wr_count", 32'(wr_count), 32'd1);
    rd_lit("oor_read", 19'h40000, 8'hFF);
    rd_lit("oor_mem0", 19'h00000, 8'h00);

    // Conflict, then clear.
    pulse_clr();
    sram_addr = 19'h00010; sram_dq_in = 8'h77;
    sram_cen = 1'b0; sram_oen = 1'b0; sram_wen = 1'b0;
    repeat (3) begin
      tick();
      chk("conflict_oe", 32'(sram_dq_oe), 32'd0);
    end
    set_idle(); repeat (3) tick();
    chk("conflict_err", 32'(conflict_err), 32'd1);
    chk("conflict_wr_count", 32'(wr_count), 32'd1);
    rd_lit("conflict_data", 19'h00010, 8'h77);
    pulse_clr();
    chk("clr_counts", 32'({rd_count, wr_count}), 32'd0);
    chk("clr_flags", 32'({conflict_err, range_err}), 32'd0);

    // Reset in the middle of a write.
    wr(19'h00020, 8'h3C, 1);
    pulse_clr();
    sram_addr = 19'h00020; sram_dq_in = 8'hEE; sram_cen = 1'b0; sram_wen = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("rstw_dq_out", 32'(sram_dq_out), 32'h00);
    chk("rstw_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstw_flags", 32'({conflict_err, range_err}), 32'd0);
    set_idle(); rst_n = 1'b1;
    repeat (3) tick();
    chk("rstw_wr_count", 32'(wr_count), 32'd0);
    rd_lit("rstw_prior", 19'h00020, 8'h3C);

    // Randomized traffic.
    op = 0; len = 0;
    for (int c = 0; c < 4000; c++) begin
      if (len == 0) begin
        op  = int'($urandom_range(0, 9));
        len = int'($urandom_range(1, 5));
        sram_addr = ($urandom_range(0, 7) == 0) ? {1'b1, 18'($urandom_range(0, 15))}
                                                : 19'($urandom_range(0, 15));
      end
      len--;
      sram_dq_in = 8'($urandom);
      if (op >= 6 && op <= 7 && $urandom_range(0, 2) == 0) sram_addr = 19'($urandom_range(0, 15));
      case (op)
        4, 5:    begin sram_cen = 1'b0; sram_oen = 1'b1; sram_wen = 1'b0; end
        6, 7:    begin sram_cen = 1'b0; sram_oen = 1'b0; sram_wen = 1'b1; end
        8:       begin sram_cen = 1'b0; sram_oen = 1'b0; sram_wen = 1'b0; end
        9:       begin sram_cen = 1'b1; sram_oen = 1'b0; sram_wen = 1'b0; end
        default: set_idle();
      endcase
      clr_stats = ($urandom_range(0, 59) == 0);
      rst_n     = !($urandom_range(0, 499) == 0);
      tick();
    end
    rst_n = 1'b1; clr_stats = 1'b0; set_idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
